hex_display_arbiter: RTL and testbench

//  Shares the board's six seven-segment digits between N_REQ requesters
//  (pattern index, frame counter, error code, ...) by round-robin arbitration.

---
 rtl/hex_display_arbiter_pkg.sv | 15 +
 rtl/hex_display_arbiter_if.sv | 27 ++
 rtl/hex_display_arbiter_hex7seg.sv | 33 +++
 rtl/hex_display_arbiter_rr_arbiter.sv | 30 +++
 rtl/hex_display_arbiter.sv | 136 +++++++++++++
 tb/tb_hex_display_arbiter.sv | 259 +++++++++++++++++++++++++
 6 files changed

// File: rtl/hex_display_arbiter_pkg.sv
// Shared types and constants for the hex display arbiter.
package hex_display_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    SHOW = 2'd3
  } state_e;

  // All segments off (segments are active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         NIB_W     = 4;

endpackage

// File: rtl/hex_display_arbiter_if.sv
// Requester-side bundle for the hex display arbiter: requests, values,
// display controls and the arbiter's status/segment outputs.
interface hex_display_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DIGITS = 6
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]          req;
  logic [N_REQ*4*DIGITS-1:0] value;
  logic                      blank_lz;
  logic                      flush;
  logic [N_REQ-1:0]          ack;
  logic [ID_W-1:0]           active_id;
  logic                      active_vld;
  logic [7*DIGITS-1:0]       hex_out;

  modport master (
    output req, value, blank_lz, flush,
    input  ack, active_id, active_vld, hex_out
  );

  modport slave (
    input  req, value, blank_lz, flush,
    output ack, active_id, active_vld, hex_out
  );
endinterface

// File: rtl/hex_display_arbiter_hex7seg.sv
// Hex nibble to active-low seven-segment pattern (bit order gfedcba).
module hex7seg
  import hex_display_arbiter_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [6:0]       seg_o
);

  // Standard hex glyph table
  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester strictly after
// the pointer (wrapping) wins, so the last owner has lowest priority.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from ptr+1 around to ptr, take the first set request
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin sharing of a multi-digit hex display between requesters.
// A grant acks for one cycle (LOAD), captures the value at the end of LOAD,
// holds it for HOLD_CYCLES, then keeps showing it (SHOW) until someone asks.
module hex_display_arbiter
  import hex_display_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int DIGITS      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  hex_display_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int VAL_W = NIB_W * DIGITS;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   active_id_q, active_id_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              active_vld_q, active_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VAL_W-1:0]  val_q;
  logic              cap;

  logic [N_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic [VAL_W-1:0]  val_arr [N_REQ];

  rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  for (genvar r = 0; r < N_REQ; r++) begin : g_val
    assign val_arr[r] = bus.value[r*VAL_W +: VAL_W];
  end

  // Next-state logic; flush overrides every state and kills ack/capture
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    active_id_d  = active_id_q;
    ack_d        = '0;
    active_vld_d = active_vld_q;
    cnt_d        = cnt_q;
    cap          = 1'b0;
    if (bus.flush) begin
      state_d      = IDLE;
      active_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, SHOW: begin
          if (arb_any) begin
            state_d = LOAD;
            grant_d = arb_idx;
            ack_d   = arb_gnt;
          end
        end
        LOAD: begin
          cap          = 1'b1;
          rr_ptr_d     = grant_q;
          active_id_d  = grant_q;
          active_vld_d = 1'b1;
          cnt_d        = CNT_LOAD;
          state_d      = HOLD;
        end
        HOLD: begin
          if (cnt_q == '0) state_d = SHOW;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(N_REQ - 1);
      grant_q      <= '0;
      active_id_q  <= '0;
      ack_q        <= '0;
      active_vld_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      active_id_q  <= active_id_d;
      ack_q        <= ack_d;
      active_vld_q <= active_vld_d;
      cnt_q        <= cnt_d;
    end
  end

  // Captured display value; only meaningful while active_vld_q is set
  always_ff @(posedge clk) begin
    if (cap) val_q <= val_arr[grant_q];
  end

  assign bus.ack        = ack_q;
  assign bus.active_id  = active_id_q;
  assign bus.active_vld = active_vld_q;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [6:0] seg_raw;
    logic       lz;

    hex7seg u_dec (
      .nib_i (val_q[d*NIB_W +: NIB_W]),
      .seg_o (seg_raw)
    );

    // Digit 0 always shows; higher digits blank when they and all above are zero
    if (d == 0) begin : g_lsd
      assign lz = 1'b0;
    end else begin : g_upper
      assign lz = bus.blank_lz && ~|val_q[VAL_W-1:d*NIB_W];
    end

    assign bus.hex_out[d*7 +: 7] = (!active_vld_q || lz) ? SEG_BLANK : seg_raw;
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter with a short hold time.
module tb_hex_display_arbiter;

  localparam int N_REQ  = 4;
  localparam int HOLD   = 8;
  localparam int DIGITS = 6;
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  logic clk = 1'b0;
  logic rst;

  hex_display_arbiter_if #(.N_REQ(N_REQ), .DIGITS(DIGITS)) dut_if ();

  hex_display_arbiter #(.N_REQ(N_REQ), .HOLD_CYCLES(HOLD), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  typedef struct {
    int          id;
    logic [23:0] val;
    logic        blz;
    logic [41:0] exp_hex;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  function automatic logic [41:0] model_hex(input logic [23:0] v);
    logic [41:0] h;
    for (int d = 0; d < 6; d++) h[d*7 +: 7] = seg7(v[d*4 +: 4]);
    return h;
  endfunction

  // Wait (bounded) for any ack, then pop the scoreboard and compare the winner
  task automatic wait_ack(input int budget, output int cycles);
    int id;
    cycles = 0;
    while (dut_if.ack == '0 && cycles < budget) begin
      tick();
      cycles++;
    end
    if (dut_if.ack == '0) begin
      check("ack_timeout", 64'(0), 64'(1));
    end else if (exp_q.size() == 0) begin
      check("sb_unexpected_ack", 64'(dut_if.ack), 64'(0));
    end else begin
      id = exp_q.pop_front();
      check("ack_id", 64'(dut_if.ack), 64'(1 << id));
    end
  endtask

  task automatic apply_reset();
    dut_if.req   = '0;
    dut_if.flush = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_flush();
    dut_if.flush = 1'b1;
    tick();
    dut_if.flush = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int cnt_ack;
    int last;
    int pend_id;
    logic [23:0] rr_val [4];

    rst             = 1'b1;
    dut_if.req      = '0;
    dut_if.value    = '0;
    dut_if.blank_lz = 1'b0;
    dut_if.flush    = 1'b0;

    // Reset state and idle with no requests
    repeat (3) tick();
    check("rst_hex", 64'(dut_if.hex_out), 64'(ALL_BLANK));
    check("rst_vld", 64'(dut_if.active_vld), 64'(0));
    check("rst_ack", 64'(dut_if.ack), 64'(0));
    check("rst_id",  64'(dut_if.active_id), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("idle_ack", 64'(dut_if.ack), 64'(0));
      check("idle_hex", 64'(dut_if.hex_out), 64'(ALL_BLANK));
    end

    // Decode / leading-zero table
    vecs[0] = '{id: 2, val: 24'h000A3F, blz: 1'b1, exp_hex: {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E}};
    vecs[1] = '{id: 0, val: 24'h000000, blz: 1'b1, exp_hex: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[2] = '{id: 1, val: 24'h000000, blz: 1'b0, exp_hex: {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[3] = '{id: 3, val: 24'h123456, blz: 1'b1, exp_hex: {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
    vecs[4] = '{id: 1, val: 24'h0F0000, blz: 1'b1, exp_hex: {7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{id: 3, val: 24'hABCDEF, blz: 1'b0, exp_hex: {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
    vecs[6] = '{id: 0, val: 24'h000100, blz: 1'b0, exp_hex: {7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40}};
    vecs[7] = '{id: 2, val: 24'h800000, blz: 1'b1, exp_hex: {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

    for (int i = 0; i < 8; i++) begin
      do_flush();
      dut_if.value = {$urandom(), $urandom(), $urandom()};
      dut_if.value[vecs[i].id*24 +: 24] = vecs[i].val;
      dut_if.blank_lz = vecs[i].blz;
      dut_if.req = 4'(1 << vecs[i].id);
      exp_q.push_back(vecs[i].id);
      wait_ack(4, cyc);
      check("vec_ack_latency", 64'(cyc), 64'(1));
      dut_if.req = '0;
      tick();
      check("vec_hex", 64'(dut_if.hex_out), 64'(vecs[i].exp_hex));
      check("vec_id",  64'(dut_if.active_id), 64'(vecs[i].id));
      check("vec_vld", 64'(dut_if.active_vld), 64'(1));
      if (i == 0) begin
        dut_if.blank_lz = 1'b0;
        #1;
        check("lz_live_off", 64'(dut_if.hex_out),
              64'({7'h40, 7'h40, 7'h40, 7'h08, 7'h30, 7'h0E}));
      end
    end

    // All requesting: round-robin order 0,1,2,3,0 from reset
    apply_reset();
    dut_if.blank_lz = 1'b0;
    rr_val = '{24'h00C0DE, 24'h1F2E3D, 24'h456789, 24'h0000B7};
    for (int r = 0; r < 4; r++) dut_if.value[r*24 +: 24] = rr_val[r];
    exp_q = '{0, 1, 2, 3, 0};
    dut_if.req = 4'b1111;
    cnt_ack = 0;
    last = 0;
    pend_id = -1;
    for (int c = 0; c < 120 && (cnt_ack < 5 || pend_id >= 0); c++) begin
      tick();
      if (pend_id >= 0) begin
        check("rr_pulse_len", 64'(dut_if.ack), 64'(0));
        check("rr_hex", 64'(dut_if.hex_out), 64'(model_hex(rr_val[pend_id])));
        check("rr_id", 64'(dut_if.active_id), 64'(pend_id));
        pend_id = -1;
      end else if (dut_if.ack != '0) begin
        if (exp_q.size() == 0) begin
          check("rr_extra_ack", 64'(dut_if.ack), 64'(0));
        end else begin
          pend_id = exp_q.pop_front();
          check("rr_ack", 64'(dut_if.ack), 64'(1 << pend_id));
          if (cnt_ack > 0) check("rr_hold_long_enough", 64'((c - last) >= HOLD + 2), 64'(1));
          last = c;
          cnt_ack++;
        end
      end
    end
    check("rr_ack_count", 64'(cnt_ack), 64'(5));
    dut_if.req = '0;

    // Request during HOLD is deferred until the counter expires
    apply_reset();
    dut_if.value[0 +: 24] = 24'h000777;
    dut_if.req = 4'b0001;
    exp_q.push_back(0);
    wait_ack(4, cyc);
    check("hold_ack0_latency", 64'(cyc), 64'(1));
    dut_if.req = '0;
    tick();
    dut_if.req = 4'b0010;
    exp_q.push_back(1);
    wait_ack(30, cyc);
    check("hold_ack1_latency", 64'(cyc), 64'(HOLD + 1));
    dut_if.req = '0;

    // Flush during HOLD
    tick();
    check("fl_pre_vld", 64'(dut_if.active_vld), 64'(1));
    tick();
    do_flush();
    check("fl_hold_vld", 64'(dut_if.active_vld), 64'(0));
    check("fl_hold_hex", 64'(dut_if.hex_out), 64'(ALL_BLANK));
    check("fl_hold_ack", 64'(dut_if.ack), 64'(0));

    // Flush coincident with the arbitration that would enter LOAD
    dut_if.value[3*24 +: 24] = 24'h000D0D;
    dut_if.req = 4'b1000;
    exp_q.push_back(3);
    do_flush();
    check("fl_load_no_ack", 64'(dut_if.ack), 64'(0));
    wait_ack(4, cyc);
    check("fl_retry_latency", 64'(cyc), 64'(1));
    // Flush while in LOAD: capture dropped, display stays blank
    dut_if.req = '0;
    do_flush();
    check("fl_in_load_vld", 64'(dut_if.active_vld), 64'(0));
    check("fl_in_load_hex", 64'(dut_if.hex_out), 64'(ALL_BLANK));
    tick();
    check("fl_after_vld", 64'(dut_if.active_vld), 64'(0));
    check("fl_after_ack", 64'(dut_if.ack), 64'(0));

    // Asynchronous reset in the middle of HOLD
    dut_if.blank_lz = 1'b1;
    dut_if.value[2*24 +: 24] = 24'h00ABCD;
    dut_if.req = 4'b0100;
    exp_q.push_back(2);
    wait_ack(4, cyc);
    dut_if.req = '0;
    repeat (3) tick();
    check("ar_pre_vld", 64'(dut_if.active_vld), 64'(1));
    check("ar_pre_id",  64'(dut_if.active_id), 64'(2));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("ar_vld", 64'(dut_if.active_vld), 64'(0));
    check("ar_hex", 64'(dut_if.hex_out), 64'(ALL_BLANK));
    check("ar_ack", 64'(dut_if.ack), 64'(0));
    check("ar_id",  64'(dut_if.active_id), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    check("ar_post_hex", 64'(dut_if.hex_out), 64'(ALL_BLANK));
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
